hack_rom_loader: RTL and testbench

Instruction-memory responder for the hack CPU. It accepts a program over a byte stream with a valid/ready handshake, typically from a UART receiver, and assembles the bytes into 16-bit words in an internal ROM. It holds the CPU in reset while loading. In run mode it serves instr = ROM[PC] combinationally, which is the fetch side the CPU's PC drives.

---
 rtl/hack_pkg.sv | 26 ++
 rtl/hack_rom_mem.sv | 26 ++
 rtl/hack_rom_loader.sv | 167 ++++++++++++++++
 tb/tb_hack_rom_loader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared types and widths for the hack CPU ROM loader.
// Optional checksum states are enabled by HACK_LOADER_CHECKSUM_EN.
package hack_pkg;

   localparam int INSTR_W = 16;
   localparam int PC_W    = 15;
   localparam int BYTE_W  = 8;

   typedef enum logic [3:0] {
      IDLE,
      CNT_HI,
      CNT_LO,
      WORD_HI,
      WORD_LO,
      SUM_HI,
      SUM_LO,
      RUN,
      ERROR
   } state_e;

   // States in which the loader takes bytes from the stream.
   function automatic logic accepts_bytes(input state_e s);
      return s inside {CNT_HI, CNT_LO, WORD_HI, WORD_LO, SUM_HI, SUM_LO};
   endfunction

endpackage

// File: rtl/hack_rom_mem.sv
// Instruction ROM storage: one synchronous write port, one asynchronous read port.
// No optional features (HACK_LOADER_CHECKSUM_EN does not affect this file).
module hack_rom_mem
   import hack_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic               clk,
   input  logic               we,
   input  logic [ADDR_W-1:0]  waddr,
   input  logic [INSTR_W-1:0] wdata,
   input  logic [ADDR_W-1:0]  raddr,
   output logic [INSTR_W-1:0] rdata
);

   logic [INSTR_W-1:0] mem_q [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/hack_rom_loader.sv
// Byte-stream program loader and fetch port for the hack CPU ROM.
// Define HACK_LOADER_CHECKSUM_EN to require a trailing 16-bit word checksum.
module hack_rom_loader
   import hack_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_req,
   input  logic [BYTE_W-1:0]  rx_data,
   input  logic               rx_valid,
   output logic               rx_ready,
   input  logic [PC_W-1:0]    pc,
   output logic [INSTR_W-1:0] instr,
   output logic               cpu_reset,
   output logic               load_done,
   output logic               error,
   output logic [ADDR_W:0]    word_count
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

`ifdef HACK_LOADER_CHECKSUM_EN
   localparam state_e AFTER_WORDS = SUM_HI;
`else
   localparam state_e AFTER_WORDS = RUN;
`endif

   state_e              state_q, state_d;
   logic                rx_ready_q, rx_ready_d;
   logic [BYTE_W-1:0]   hi_q, hi_d;
   logic [15:0]         n_q, n_d;
   logic [ADDR_W:0]     word_count_q, word_count_d;
`ifdef HACK_LOADER_CHECKSUM_EN
   logic [15:0]         sum_q, sum_d;
`endif

   logic                xfer;
   logic [15:0]         n_rx;
   logic [16:0]         count_next;
   logic                we;
   logic [ADDR_W-1:0]   waddr;
   logic [INSTR_W-1:0]  wdata;
   logic [ADDR_W-1:0]   raddr;
   logic [INSTR_W-1:0]  rdata;

   assign xfer = rx_valid & rx_ready_q;

   always_comb begin
      state_d      = state_q;
      hi_d         = hi_q;
      n_d          = n_q;
      word_count_d = word_count_q;
`ifdef HACK_LOADER_CHECKSUM_EN
      sum_d        = sum_q;
`endif
      n_rx         = {n_q[15:8], rx_data};
      count_next   = 17'(word_count_q) + 17'd1;
      we           = 1'b0;
      waddr        = word_count_q[ADDR_W-1:0];
      wdata        = {hi_q, rx_data};

      case (state_q)
         IDLE, RUN, ERROR: begin
            if (load_req) state_d = CNT_HI;
         end
         CNT_HI: begin
            if (xfer) begin
               n_d[15:8] = rx_data;
               state_d   = CNT_LO;
            end
         end
         CNT_LO: begin
            if (xfer) begin
               n_d          = n_rx;
               word_count_d = '0;
`ifdef HACK_LOADER_CHECKSUM_EN
               sum_d        = '0;
`endif
               if (17'(n_rx) > 17'(DEPTH)) state_d = ERROR;
               else if (n_rx == 16'd0)     state_d = AFTER_WORDS;
               else                        state_d = WORD_HI;
            end
         end
         WORD_HI: begin
            if (xfer) begin
               hi_d    = rx_data;
               state_d = WORD_LO;
            end
         end
         WORD_LO: begin
            if (xfer) begin
               we           = 1'b1;
               word_count_d = count_next[ADDR_W:0];
`ifdef HACK_LOADER_CHECKSUM_EN
               sum_d        = sum_q + wdata;
`endif
               state_d      = (count_next == 17'(n_q)) ? AFTER_WORDS : WORD_HI;
            end
         end
`ifdef HACK_LOADER_CHECKSUM_EN
         SUM_HI: begin
            if (xfer) begin
               hi_d    = rx_data;
               state_d = SUM_LO;
            end
         end
         SUM_LO: begin
            if (xfer) state_d = ({hi_q, rx_data} == sum_q) ? RUN : ERROR;
         end
`endif
         default: state_d = IDLE;
      endcase

      rx_ready_d = accepts_bytes(state_d);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         rx_ready_q   <= 1'b0;
         hi_q         <= '0;
         n_q          <= '0;
         word_count_q <= '0;
`ifdef HACK_LOADER_CHECKSUM_EN
         sum_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         rx_ready_q   <= rx_ready_d;
         hi_q         <= hi_d;
         n_q          <= n_d;
         word_count_q <= word_count_d;
`ifdef HACK_LOADER_CHECKSUM_EN
         sum_q        <= sum_d;
`endif
      end
   end

   hack_rom_mem #(
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (raddr),
      .rdata (rdata)
   );

   // Full-width pc compare: any pc bit above ADDR_W makes the fetch out of range.
   always_comb begin
      raddr = pc[ADDR_W-1:0];
      instr = '0;
      if ((17'(pc) < 17'(word_count_q)) && (17'(pc) < 17'(DEPTH))) begin
         instr = rdata;
      end
   end

   assign rx_ready   = rx_ready_q;
   assign cpu_reset  = (state_q != RUN);
   assign load_done  = (state_q == RUN);
   assign error      = (state_q == ERROR);
   assign word_count = word_count_q;

endmodule

// File: tb/tb_hack_rom_loader.sv
// Self-checking bench for hack_rom_loader against a stream-level ROM model.
// Checksum sequences are compiled in when HACK_LOADER_CHECKSUM_EN is defined.
module tb_hack_rom_loader;

   localparam int ADDR_W = 8;
   localparam int DEPTH  = 256;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              load_req;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic [14:0]       pc;
   logic [15:0]       instr;
   logic              cpu_reset;
   logic              load_done;
   logic              error;
   logic [ADDR_W:0]   word_count;

   always #5 clk = ~clk;

   hack_rom_loader #(
      .ADDR_W (ADDR_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_req   (load_req),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .pc         (pc),
      .instr      (instr),
      .cpu_reset  (cpu_reset),
      .load_done  (load_done),
      .error      (error),
      .word_count (word_count)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: what the CPU should see after a complete stream.
   logic [15:0] m_rom [DEPTH];
   int          m_count;
   bit          m_err;

   logic [15:0] wq[$];
   logic [7:0]  bq[$];

   typedef struct {
      logic [14:0] pc;
      logic [15:0] exp;
   } vec_t;
   vec_t tbl[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] m_fetch(input int p);
      return (p < m_count) ? m_rom[p] : 16'h0000;
   endfunction

   task automatic check_pc(input int p);
      pc = 15'(p);
      #1;
      chk($sformatf("instr pc=%0h", p), {16'h0, instr}, {16'h0, m_fetch(p)});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load();
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
      chk("rx_ready at load start", {31'h0, rx_ready}, 32'd1);
      chk("cpu_reset at load start", {31'h0, cpu_reset}, 32'd1);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t;
      rx_data  = b;
      rx_valid = 1'b1;
      t = 0;
      while (rx_ready !== 1'b1 && t < 40) begin
         tick();
         t++;
      end
      if (t == 40) begin
         chk("rx_ready timeout", 32'd0, 32'd1);
      end else begin
         chk("cpu_reset during load", {31'h0, cpu_reset}, 32'd1);
         tick();
      end
      rx_valid = 1'b0;
   endtask

   task automatic do_load(input int n, input int gap, input bit bad_sum);
      int unsigned s;
      int          idle;
      s = 0;
      bq.delete();
      bq.push_back(8'(n >> 8));
      bq.push_back(8'(n));
      if (n <= DEPTH) begin
         for (int i = 0; i < n; i++) begin
            bq.push_back(wq[i][15:8]);
            bq.push_back(wq[i][7:0]);
            s += int'(wq[i]);
         end
`ifdef HACK_LOADER_CHECKSUM_EN
         s = (s + (bad_sum ? 1 : 0)) & 32'hFFFF;
         bq.push_back(8'(s >> 8));
         bq.push_back(8'(s));
`endif
      end

      start_load();
      for (int i = 0; i < bq.size(); i++) begin
         idle = 0;
         if (i > 0 && gap == 1) idle = 1;
         if (gap == 2) idle = $urandom_range(0, 2);
         for (int k = 0; k < idle; k++) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            tick();
            chk("rx_ready in gap", {31'h0, rx_ready}, 32'd1);
         end
         send_byte(bq[i]);
      end

      if (n > DEPTH) begin
         m_count = 0;
         m_err   = 1'b1;
      end else begin
         for (int i = 0; i < n; i++) m_rom[i] = wq[i];
         m_count = n;
         m_err   = 1'b0;
`ifdef HACK_LOADER_CHECKSUM_EN
         m_err   = bad_sum;
`endif
      end

      chk("load_done", {31'h0, load_done}, {31'h0, !m_err});
      chk("error", {31'h0, error}, {31'h0, m_err});
      chk("cpu_reset", {31'h0, cpu_reset}, {31'h0, m_err});
      chk("word_count", {23'h0, word_count}, 32'(m_count));
      chk("rx_ready after load", {31'h0, rx_ready}, 32'd0);
      for (int p = 0; p <= m_count + 1 && p <= DEPTH; p++) check_pc(p);
      check_pc(int'($urandom_range(0, 32767)));
      check_pc(32767);
   endtask

   task automatic rand_words(input int n);
      wq.delete();
      for (int i = 0; i < n && i <= DEPTH; i++) wq.push_back(16'($urandom));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tbl[0] = '{15'h0000, 16'h0005};
      tbl[1] = '{15'h0001, 16'hEC10};
      tbl[2] = '{15'h0002, 16'h1234};
      tbl[3] = '{15'h0003, 16'h0000};
      tbl[4] = '{15'h00FF, 16'h0000};
      tbl[5] = '{15'h0100, 16'h0000};
      tbl[6] = '{15'h4001, 16'h0000};
      tbl[7] = '{15'h7FFF, 16'h0000};

      rst_n = 1'b0; load_req = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; pc = '0;
      m_count = 0; m_err = 1'b0;
      tick(); tick();
      chk("reset rx_ready", {31'h0, rx_ready}, 32'd0);
      chk("reset cpu_reset", {31'h0, cpu_reset}, 32'd1);
      chk("reset load_done", {31'h0, load_done}, 32'd0);
      chk("reset error", {31'h0, error}, 32'd0);
      chk("reset word_count", {23'h0, word_count}, 32'd0);
      check_pc(0);
      rst_n = 1'b1;
      tick();
      chk("idle rx_ready", {31'h0, rx_ready}, 32'd0);

      // Basic three-word program, rx_valid held high.
      wq = '{16'h0005, 16'hEC10, 16'h1234};
      do_load(3, 0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         pc = tbl[i].pc;
         #1;
         chk($sformatf("tbl[%0d] instr", i), {16'h0, instr}, {16'h0, tbl[i].exp});
      end

      // Same stream with rx_valid toggling.
      do_load(3, 1, 1'b0);

      // Oversized header goes to ERROR, then an empty program recovers.
      do_load(257, 0, 1'b0);
      wq.delete();
      do_load(0, 2, 1'b0);

      // Reload from RUN hides stale words.
      wq = '{16'h0005, 16'hEC10, 16'h1234};
      do_load(3, 0, 1'b0);
      wq = '{16'hABCD};
      do_load(1, 0, 1'b0);

      // Full ROM boundary.
      rand_words(DEPTH);
      do_load(DEPTH, 0, 1'b0);

      for (int it = 0; it < 25; it++) begin
         int n;
         n = ($urandom_range(0, 5) == 0) ? int'($urandom_range(257, 2000))
                                         : int'($urandom_range(0, 16));
         rand_words(n);
         do_load(n, int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0));
      end

`ifdef HACK_LOADER_CHECKSUM_EN
      wq = '{16'h0001, 16'h0002};
      do_load(2, 0, 1'b0);
      do_load(2, 0, 1'b1);
`endif

      // Reset right after the first WORD_HI transfer.
      start_load();
      send_byte(8'h00);
      send_byte(8'h03);
      send_byte(8'h00);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      m_count = 0;
      chk("midreset rx_ready", {31'h0, rx_ready}, 32'd0);
      chk("midreset word_count", {23'h0, word_count}, 32'd0);
      chk("midreset cpu_reset", {31'h0, cpu_reset}, 32'd1);
      chk("midreset load_done", {31'h0, load_done}, 32'd0);
      chk("midreset error", {31'h0, error}, 32'd0);
      for (int p = 0; p < 4; p++) check_pc(p);
      rx_valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         rx_data = 8'($urandom);
         tick();
         chk("no load_req rx_ready", {31'h0, rx_ready}, 32'd0);
      end
      rx_valid = 1'b0;
      chk("no load_req word_count", {23'h0, word_count}, 32'd0);
      chk("no load_req cpu_reset", {31'h0, cpu_reset}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
